// File: rtl/trim_rx_pkg.sv
// -----------------------------------------------------------------------------
// trim_rx_pkg
// Shared definitions for the serial trim-code receiver:
//   state_t        FSM state encoding (IDLE=0, RECV=1, DONE=2)
//   TRIM_WIDTH_DEF default trim word width
//   BIT_CNT_W      width of the received-bit counter (saturates at BIT_CNT_MAX)
//   sat_inc()      saturating increment for the bit counter
// -----------------------------------------------------------------------------
package trim_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TRIM_WIDTH_DEF = 12;
  localparam int BIT_CNT_W      = 5;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 5'd31;

  // Bit counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] v);
    logic [BIT_CNT_W-1:0] r;
    if (v == BIT_CNT_MAX) begin
      r = v;
    end else begin
      r = v + BIT_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/trim_sync.sv
// -----------------------------------------------------------------------------
// trim_sync
// Brings the asynchronous ENCLK/DIN pins into the CLOCK_50 domain and turns
// ENCLK transitions into single-cycle rise/fall pulses.
// Optional feature macro: TRIM_RX_DEGLITCH_EN -- when defined, the synchronized
// ENCLK level only changes after FILT_CYCLES consecutive equal samples.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous reset, active-low
//   i_enclk  raw serial clock pin (idle low)
//   i_din    raw serial data pin
//   o_din_s  synchronized data (2-FF)
//   o_rise   one-cycle pulse on a detected ENCLK rising edge
//   o_fall   one-cycle pulse on a detected ENCLK falling edge
// -----------------------------------------------------------------------------
module trim_sync
  import trim_rx_pkg::*;
#(
  parameter int FILT_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enclk,
  input  logic i_din,
  output logic o_din_s,
  output logic o_rise,
  output logic o_fall
);

  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("trim_sync: FILT_CYCLES must be at least 1");
  end

  logic r_enclk_meta;
  logic r_enclk_sync;
  logic r_enclk_prev;
  logic r_din_meta;
  logic r_din_sync;
  logic w_enclk_lvl;

  // Two-stage synchronizers for both pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enclk_meta <= 1'b0;
      r_enclk_sync <= 1'b0;
      r_din_meta   <= 1'b0;
      r_din_sync   <= 1'b0;
    end else begin
      r_enclk_meta <= i_enclk;
      r_enclk_sync <= r_enclk_meta;
      r_din_meta   <= i_din;
      r_din_sync   <= r_din_meta;
    end
  end

`ifdef TRIM_RX_DEGLITCH_EN
  localparam int FW = $clog2(FILT_CYCLES) + 1;

  logic          r_enclk_filt;
  logic [FW-1:0] r_filt_cnt;

  // Accept a new ENCLK level only once it has persisted for FILT_CYCLES samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enclk_filt <= 1'b0;
      r_filt_cnt   <= {FW{1'b0}};
    end else if (r_enclk_sync == r_enclk_filt) begin
      r_filt_cnt   <= {FW{1'b0}};
    end else if (r_filt_cnt == FW'(FILT_CYCLES - 1)) begin
      r_enclk_filt <= r_enclk_sync;
      r_filt_cnt   <= {FW{1'b0}};
    end else begin
      r_filt_cnt   <= r_filt_cnt + FW'(1);
    end
  end

  assign w_enclk_lvl = r_enclk_filt;
`else
  assign w_enclk_lvl = r_enclk_sync;
`endif

  // Delayed copy of the (possibly filtered) level for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enclk_prev <= 1'b0;
    end else begin
      r_enclk_prev <= w_enclk_lvl;
    end
  end

  assign o_din_s = r_din_sync;
  assign o_rise  = w_enclk_lvl & ~r_enclk_prev;
  assign o_fall  = ~w_enclk_lvl & r_enclk_prev;

endmodule

// File: rtl/trim_rx.sv
// -----------------------------------------------------------------------------
// trim_rx
// Receiver for the serial ENCLK/DOUT trim-code link. Shifts in DIN LSB-first on
// each detected ENCLK falling edge and, once ENCLK has been quiet for
// IDLE_CYCLES, reports the last WIDTH bits (VALID) or flags a short frame (ERR).
// Optional feature macro: TRIM_RX_DEGLITCH_EN (ENCLK deglitch filter in trim_sync).
// Ports:
//   CLOCK_50   system clock, sole clock of the block
//   RST_N      asynchronous reset, active-low
//   ENCLK      serial clock from the transmitter, asynchronous, idle low
//   DIN        serial data, changes on ENCLK rise
//   TRIM_CODE  last complete received word
//   VALID      one-cycle pulse when TRIM_CODE updates
//   ERR        one-cycle pulse on a frame shorter than WIDTH bits
//   BUSY       high while a frame is in progress
//   BIT_CNT    bits received in the current/last frame, saturating at 31
// -----------------------------------------------------------------------------
module trim_rx
  import trim_rx_pkg::*;
#(
  parameter int WIDTH       = TRIM_WIDTH_DEF,
  parameter int IDLE_CYCLES = 20000000,
  parameter int FILT_CYCLES = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RST_N,
  input  logic                 ENCLK,
  input  logic                 DIN,
  output logic [WIDTH-1:0]     TRIM_CODE,
  output logic                 VALID,
  output logic                 ERR,
  output logic                 BUSY,
  output logic [BIT_CNT_W-1:0] BIT_CNT
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
  localparam logic [BIT_CNT_W-1:0] WIDTH_CNT = BIT_CNT_W'(WIDTH);

  logic w_din_s;
  logic w_rise;
  logic w_fall;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_sreg;
  logic [IDLE_W-1:0]     r_idle_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0]      r_code;
  logic                  r_valid;
  logic                  r_err;
  logic                  r_busy;

  trim_sync #(
    .FILT_CYCLES (FILT_CYCLES)
  ) u_sync (
    .i_clk   (CLOCK_50),
    .i_rst_n (RST_N),
    .i_enclk (ENCLK),
    .i_din   (DIN),
    .o_din_s (w_din_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; edges seen during DONE are deliberately dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_RECV;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (r_idle_cnt == IDLE_MAX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RECV;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register and bit counter: cleared at frame start, advanced on falls.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_sreg    <= {WIDTH{1'b0}};
      r_bit_cnt <= {BIT_CNT_W{1'b0}};
    end else if ((r_state == ST_IDLE) && w_rise) begin
      r_sreg    <= {WIDTH{1'b0}};
      r_bit_cnt <= {BIT_CNT_W{1'b0}};
    end else if ((r_state == ST_RECV) && w_fall) begin
      r_sreg    <= {w_din_s, r_sreg[WIDTH-1:1]};
      r_bit_cnt <= sat_inc(r_bit_cnt);
    end else begin
      r_sreg    <= r_sreg;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Quiet-time counter: any ENCLK edge restarts it; it parks at IDLE_MAX.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_idle_cnt <= {IDLE_W{1'b0}};
    end else if ((r_state != ST_RECV) || w_rise || w_fall) begin
      r_idle_cnt <= {IDLE_W{1'b0}};
    end else if (r_idle_cnt != IDLE_MAX) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end else begin
      r_idle_cnt <= r_idle_cnt;
    end
  end

  // Frame verdict in DONE plus registered BUSY.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_code  <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_DONE) begin
        if (r_bit_cnt >= WIDTH_CNT) begin
          r_code  <= r_sreg;
          r_valid <= 1'b1;
        end else begin
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign TRIM_CODE = r_code;
  assign VALID     = r_valid;
  assign ERR       = r_err;
  assign BUSY      = r_busy;
  assign BIT_CNT   = r_bit_cnt;

endmodule

// File: tb/tb_trim_rx.sv
// -----------------------------------------------------------------------------
// tb_trim_rx
// Self-checking bench for trim_rx (IDLE_CYCLES=50, ENCLK period 20 CLOCK_50
// cycles). Directed table vectors, hand-written multi-cycle sequences and
// random frames judged by a behavioural model of the trim link.
// -----------------------------------------------------------------------------
module tb_trim_rx;

  localparam int WIDTH = 12;
  localparam int IDLE  = 50;
  localparam int FILT  = 4;
  localparam int HALF  = 10;
`ifdef TRIM_RX_DEGLITCH_EN
  localparam int EXP_LAT = 3 + FILT + IDLE + 2;
`else
  localparam int EXP_LAT = 3 + IDLE + 2;
`endif

  logic             CLOCK_50 = 1'b0;
  logic             RST_N;
  logic             ENCLK;
  logic             DIN;
  logic [WIDTH-1:0] TRIM_CODE;
  logic             VALID;
  logic             ERR;
  logic             BUSY;
  logic [4:0]       BIT_CNT;

  always #5 CLOCK_50 = ~CLOCK_50;

  trim_rx #(
    .WIDTH       (WIDTH),
    .IDLE_CYCLES (IDLE),
    .FILT_CYCLES (FILT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RST_N     (RST_N),
    .ENCLK     (ENCLK),
    .DIN       (DIN),
    .TRIM_CODE (TRIM_CODE),
    .VALID     (VALID),
    .ERR       (ERR),
    .BUSY      (BUSY),
    .BIT_CNT   (BIT_CNT)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Pulse monitor: counts VALID/ERR pulses and protocol violations.
  int   n_valid    = 0;
  int   n_err      = 0;
  int   mon_viol   = 0;
  logic prev_pulse = 1'b0;

  always @(negedge CLOCK_50) begin
    if (VALID) n_valid <= n_valid + 1;
    if (ERR)   n_err   <= n_err + 1;
    if ((VALID && ERR) || ((VALID || ERR) && prev_pulse)) mon_viol <= mon_viol + 1;
    prev_pulse <= VALID || ERR;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          nbits;
    logic [39:0] bits;
    logic        exp_valid;
    logic [11:0] exp_code;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t        vecs[7];
  logic [11:0] model_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the word is the last WIDTH bits sent, the earliest of them at bit 0.
  function automatic logic [11:0] last_word(input logic [39:0] bits, input int n);
    logic [11:0] w;
    w = 12'h000;
    for (int i = 0; i < WIDTH; i++) w[i] = bits[n - WIDTH + i];
    return w;
  endfunction

  function automatic logic [4:0] model_cnt(input int n);
    return (n > 31) ? 5'd31 : 5'(n);
  endfunction

  // Send n bits LSB first; glitch_at puts a 2-cycle ENCLK pulse in that bit's low phase.
  task automatic send_frame(input logic [39:0] bits, input int n, input int glitch_at);
    @(negedge CLOCK_50);
    for (int i = 0; i < n; i++) begin
      DIN   = bits[i];
      ENCLK = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      ENCLK = 1'b0;
      if (i == glitch_at) begin
        repeat (4) @(negedge CLOCK_50);
        ENCLK = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        ENCLK = 1'b0;
        repeat (4) @(negedge CLOCK_50);
      end else begin
        repeat (HALF) @(negedge CLOCK_50);
      end
    end
  endtask

  task automatic wait_result(input string tag, output int lat);
    int k;
    k = 0;
    while (!(VALID || ERR) && (k < 400)) begin
      @(negedge CLOCK_50);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < 400), 32'd1);
    lat = HALF + k;
  endtask

  task automatic run_frame(input string tag, input logic [39:0] bits, input int n,
                           input int glitch_at, input logic exp_valid,
                           input logic [11:0] exp_code, input logic [4:0] exp_cnt);
    int v0, e0, lat;
    v0 = n_valid;
    e0 = n_err;
    send_frame(bits, n, glitch_at);
    check({tag, "_busy_in_frame"}, 32'(BUSY), 32'd1);
    wait_result(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
    repeat (3) @(negedge CLOCK_50);
    check({tag, "_code"}, 32'(TRIM_CODE), 32'(exp_code));
    check({tag, "_bit_cnt"}, 32'(BIT_CNT), 32'(exp_cnt));
    check({tag, "_valid_pulses"}, 32'(n_valid - v0), 32'(exp_valid));
    check({tag, "_err_pulses"}, 32'(n_err - e0), 32'(!exp_valid));
    check({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    check({tag, "_pulse_protocol"}, 32'(mon_viol), 32'd0);
    repeat (100) @(negedge CLOCK_50);
  endtask

  initial begin
    logic [39:0] rbits;
    logic [39:0] gbits;
    int          rn, v0, e0;
    logic [11:0] exp_code;
    logic [4:0]  exp_cnt;

    vecs[0] = '{12, 40'h7BF,        1'b1, 12'h7BF, 5'd12};
    vecs[1] = '{14, 40'h1EFC,       1'b1, 12'h7BF, 5'd14};
    vecs[2] = '{5,  40'h15,         1'b0, 12'h7BF, 5'd5};
    vecs[3] = '{11, 40'h7FF,        1'b0, 12'h7BF, 5'd11};
    vecs[4] = '{12, 40'h001,        1'b1, 12'h001, 5'd12};
    vecs[5] = '{12, 40'hFFE,        1'b1, 12'hFFE, 5'd12};
    vecs[6] = '{33, 40'h1_2345_6789, 1'b1, 12'h91A, 5'd31};

    RST_N = 1'b0;
    ENCLK = 1'b0;
    DIN   = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_code", 32'(TRIM_CODE), 32'd0);
    check("reset_valid", 32'(VALID), 32'd0);
    check("reset_err", 32'(ERR), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_bit_cnt", 32'(BIT_CNT), 32'd0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    model_code = 12'h000;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits, -1,
                vecs[i].exp_valid, vecs[i].exp_code, vecs[i].exp_cnt);
      if (vecs[i].exp_valid) model_code = vecs[i].exp_code;
    end

    // Reset in the middle of a frame discards it silently.
    v0 = n_valid;
    e0 = n_err;
    send_frame(40'h2D, 6, -1);
    @(negedge CLOCK_50);
    RST_N = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("midrst_code", 32'(TRIM_CODE), 32'd0);
    check("midrst_bit_cnt", 32'(BIT_CNT), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    RST_N = 1'b1;
    repeat (100) @(negedge CLOCK_50);
    check("midrst_no_pulse", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    model_code = 12'h000;
    run_frame("after_rst", 40'hA5C, 12, -1, 1'b1, 12'hA5C, 5'd12);
    model_code = 12'hA5C;

    // ENCLK stuck high after 12 bits: the frame still times out and is judged.
    v0 = n_valid;
    e0 = n_err;
    send_frame(40'hABC, 12, -1);
    ENCLK = 1'b1;
    wait_result("stuck", rn);
    repeat (3) @(negedge CLOCK_50);
    check("stuck_code", 32'(TRIM_CODE), 32'h0ABC);
    check("stuck_bit_cnt", 32'(BIT_CNT), 32'd12);
    check("stuck_valid_pulses", 32'(n_valid - v0), 32'd1);
    ENCLK = 1'b0;
    repeat (100) @(negedge CLOCK_50);
    check("stuck_release_quiet", 32'((n_valid - v0) + (n_err - e0)), 32'd1);
    check("stuck_busy", 32'(BUSY), 32'd0);
    model_code = 12'hABC;

    // Short ENCLK glitch in the low phase of bit 5.
    gbits = 40'h5A3;
`ifdef TRIM_RX_DEGLITCH_EN
    exp_code = last_word(gbits, 12);
    exp_cnt  = model_cnt(12);
`else
    gbits    = {27'd0, gbits[11:5], gbits[5:0]};
    exp_code = last_word(gbits, 13);
    exp_cnt  = model_cnt(13);
`endif
    run_frame("glitch", 40'h5A3, 12, 5, 1'b1, exp_code, exp_cnt);
    model_code = exp_code;

    // Random frames against the model.
    for (int i = 0; i < 10; i++) begin
      rn    = int'($urandom_range(1, 24));
      rbits = {8'($urandom), $urandom};
      exp_cnt = model_cnt(rn);
      if (rn >= WIDTH) model_code = last_word(rbits, rn);
      run_frame($sformatf("rnd%0d", i), rbits, rn, -1, (rn >= WIDTH), model_code, exp_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
